// File: rtl/load_store_unit.sv
// MEM-stage data-memory access unit: one request/ack bus transaction per load/store,
// byte-lane steering for stores, right-aligned load data for load_extender.
module load_store_unit #(
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_sign_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        ld_valid_o,
  output logic [31:0] ld_data_o,
  output logic [1:0]  ld_size_o,
  output logic        ld_sign_o,
  output logic        misalign_o,
  output logic        fault_o,
  output logic [31:0] fault_addr_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [TIMEOUT_W-1:0] CNT_MAX  = '1;
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = CNT_MAX - TIMEOUT_W'(1);

  state_t               state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q;
  logic                 kill_q;
  logic [1:0]           op_off_q;
  logic [1:0]           op_size_q;
  logic                 op_sign_q;

  logic        misaligned;
  logic        accept;
  logic        reject;
  logic        done;
  logic        timeout;
  logic        ld_done;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] rdata_aligned;

  always_comb begin
    misaligned = 1'b0;
    be_c       = 4'b1111;
    wdata_c    = req_wdata_i;
    unique case (req_size_i)
      2'b00: begin
        be_c    = 4'b0001 << req_addr_i[1:0];
        wdata_c = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        misaligned = req_addr_i[0];
        be_c       = 4'b0011 << req_addr_i[1:0];
        wdata_c    = {2{req_wdata_i[15:0]}};
      end
      2'b10: misaligned = |req_addr_i[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  // Terminal count is checked one step early so the fault lands after exactly
  // 2**TIMEOUT_W-1 unacknowledged BUSY cycles; an ack in that cycle still wins.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    reject  = 1'b0;
    done    = 1'b0;
    timeout = 1'b0;
    stall_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i && !flush_i) begin
          if (misaligned) begin
            reject = 1'b1;
          end else begin
            accept  = 1'b1;
            stall_o = 1'b1;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        stall_o = !dmem_ack_i;
        if (dmem_ack_i) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ld_done       = done && !dmem_we_o && !kill_q && !flush_i;
  assign rdata_aligned = dmem_rdata_i >> {op_off_q, 3'b000};

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      kill_q       <= 1'b0;
      op_off_q     <= '0;
      op_size_q    <= '0;
      op_sign_q    <= 1'b0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_be_o    <= '0;
      dmem_wdata_o <= '0;
      ld_valid_o   <= 1'b0;
      ld_data_o    <= '0;
      ld_size_o    <= '0;
      ld_sign_o    <= 1'b0;
      misalign_o   <= 1'b0;
      fault_o      <= 1'b0;
      fault_addr_o <= '0;
    end else begin
      ld_valid_o <= 1'b0;
      misalign_o <= 1'b0;
      fault_o    <= 1'b0;

      if (accept) begin
        dmem_req_o   <= 1'b1;
        dmem_we_o    <= req_write_i;
        dmem_addr_o  <= {req_addr_i[31:2], 2'b00};
        dmem_be_o    <= be_c;
        dmem_wdata_o <= wdata_c;
        op_off_q     <= req_addr_i[1:0];
        op_size_q    <= req_size_i;
        op_sign_q    <= req_sign_i;
        cnt_q        <= '0;
        kill_q       <= 1'b0;
      end

      if (reject) begin
        misalign_o   <= 1'b1;
        fault_addr_o <= req_addr_i;
      end

      if (state_q == BUSY) begin
        if (flush_i)     kill_q <= 1'b1;
        if (!dmem_ack_i) cnt_q  <= cnt_q + TIMEOUT_W'(1);
      end

      if (done) dmem_req_o <= 1'b0;

      if (timeout) begin
        dmem_req_o   <= 1'b0;
        fault_o      <= 1'b1;
        fault_addr_o <= {dmem_addr_o[31:2], op_off_q};
      end

      if (ld_done) begin
        ld_valid_o <= 1'b1;
        ld_data_o  <= rdata_aligned;
        ld_size_o  <= op_size_q;
        ld_sign_o  <= op_sign_q;
      end
    end
  end

endmodule
